mem_arbiter: RTL and testbench

- Shares the single-port instruction/data RAM between three requesters:
  - instruction fetch (IF),
  - data memory stage (DM),
  - external debug/loader port (EX).
- Sits between the CPU control/pipeline registers and the RAM, replacing the hard pc/alu_result address mux.
- Serialises accesses, inserts the RAM read latency and returns one-cycle acknowledges.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the RAM arbiter
//
// State encodings, requester ids and the default read latency used by
// mem_arbiter and mem_arb_pick.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MARB_IDLE  = 2'd0,
        MARB_ISSUE = 2'd1,
        MARB_WAIT  = 2'd2,
        MARB_ACK   = 2'd3
    } marb_state_t;

    localparam logic [1:0] MARB_ID_NONE = 2'd0;
    localparam logic [1:0] MARB_ID_DM   = 2'd1;
    localparam logic [1:0] MARB_ID_EX   = 2'd2;
    localparam logic [1:0] MARB_ID_IF   = 2'd3;

    localparam int MARB_RD_LATENCY = 1;

    // Round-robin order is DM -> EX -> IF -> DM.
    function automatic logic [1:0] marb_next_id(input logic [1:0] id);
        case (id)
            MARB_ID_DM: marb_next_id = MARB_ID_EX;
            MARB_ID_EX: marb_next_id = MARB_ID_IF;
            default:    marb_next_id = MARB_ID_DM;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the RAM arbiter
//
// Ports:
//   i_ptr   : round-robin pointer (requester id), only with MEM_ARB_ROUND_ROBIN_EN
//   i_req   : request bits, bit0 = DM, bit1 = EX, bit2 = IF
//   o_grant : winning requester id, MARB_ID_NONE when nothing requests
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise DM > EX > IF.

module mem_arb_pick
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [1:0] i_ptr,
`endif
    input  logic [2:0] i_req,
    output logic [1:0] o_grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [2:0] w_rot;
    logic [1:0] w_off;
    logic [2:0] w_sum;

    // Rotate so that w_rot[0] is the requester the pointer names, then take
    // the first set bit and rotate the offset back into a requester index.
    always_comb begin
        case (i_ptr)
            MARB_ID_EX: w_rot = {i_req[0], i_req[2:1]};
            MARB_ID_IF: w_rot = {i_req[1:0], i_req[2]};
            default:    w_rot = i_req;
        endcase

        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else               w_off = 2'd2;

        w_sum = {1'b0, i_ptr - 2'd1} + {1'b0, w_off};
        if (w_sum >= 3'd3) begin
            w_sum = w_sum - 3'd3;
        end

        if (i_req == 3'b000) begin
            o_grant = MARB_ID_NONE;
        end else begin
            o_grant = w_sum[1:0] + 2'd1;
        end
    end
`else
    always_comb begin
        if (i_req[0])      o_grant = MARB_ID_DM;
        else if (i_req[1]) o_grant = MARB_ID_EX;
        else if (i_req[2]) o_grant = MARB_ID_IF;
        else               o_grant = MARB_ID_NONE;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for IF, DM and EX requesters
//
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   if_req/if_addr               : fetch request (read only)
//   if_ack/if_rdata              : fetch completion pulse and held read data
//   dm_req/dm_wren/dm_addr/dm_wdata, dm_ack/dm_rdata : data-stage port
//   ex_req/ex_wren/ex_addr/ex_wdata, ex_ack/ex_rdata : external/loader port
//   ram_addr/ram_wdata/ram_wren/ram_rdata            : RAM side
//   busy                         : high whenever the FSM is not IDLE
// Macro MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default fixed DM > EX > IF).

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = MARB_RD_LATENCY
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_wren,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              ex_req,
    input  logic              ex_wren,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_ack,
    output logic [DATA_W-1:0] ex_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    marb_state_t       r_state;
    marb_state_t       w_next;
    logic [1:0]        r_grant;
    logic [1:0]        w_pick;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wren;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [DATA_W-1:0] r_ex_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0]        r_rr_ptr;
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_ptr   (r_rr_ptr),
`endif
        .i_req   ({if_req, ex_req, dm_req}),
        .o_grant (w_pick)
    );

    // The latched request doubles as the RAM address/data register, so the
    // RAM side keeps its last value between transactions.
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign ex_rdata  = r_ex_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MARB_IDLE:  if (w_pick != MARB_ID_NONE) w_next = MARB_ISSUE;
            MARB_ISSUE: w_next = r_wren ? MARB_ACK : MARB_WAIT;
            MARB_WAIT:  if (r_cnt == 3'd1) w_next = MARB_ACK;
            MARB_ACK:   w_next = MARB_IDLE;
            default:    w_next = MARB_IDLE;
        endcase
    end

    always_comb begin
        ram_wren = (r_state == MARB_ISSUE) && r_wren;
        dm_ack   = (r_state == MARB_ACK) && (r_grant == MARB_ID_DM);
        ex_ack   = (r_state == MARB_ACK) && (r_grant == MARB_ID_EX);
        if_ack   = (r_state == MARB_ACK) && (r_grant == MARB_ID_IF);
        busy     = (r_state != MARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant    <= MARB_ID_NONE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wren     <= 1'b0;
            r_cnt      <= 3'd0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_ex_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_ptr   <= MARB_ID_DM;
`endif
        end else begin
            case (r_state)
                MARB_IDLE: begin
                    if (w_pick != MARB_ID_NONE) begin
                        r_grant <= w_pick;
                        case (w_pick)
                            MARB_ID_DM: begin
                                r_addr  <= dm_addr;
                                r_wdata <= dm_wdata;
                                r_wren  <= dm_wren;
                            end
                            MARB_ID_EX: begin
                                r_addr  <= ex_addr;
                                r_wdata <= ex_wdata;
                                r_wren  <= ex_wren;
                            end
                            default: begin
                                // Fetch is read-only; write data is left as it was.
                                r_addr  <= if_addr;
                                r_wren  <= 1'b0;
                            end
                        endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= marb_next_id(w_pick);
`endif
                    end
                end
                MARB_ISSUE: begin
                    if (!r_wren) begin
                        r_cnt <= 3'(RD_LATENCY);
                    end
                end
                MARB_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // Count of 1 marks the cycle the RAM output is valid.
                    if (r_cnt == 3'd1) begin
                        case (r_grant)
                            MARB_ID_DM: r_dm_rdata <= ram_rdata;
                            MARB_ID_EX: r_ex_rdata <= ram_rdata;
                            MARB_ID_IF: r_if_rdata <= ram_rdata;
                            default:    ;
                        endcase
                    end
                end
                MARB_ACK: begin
                    r_grant <= MARB_ID_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int          LAT    = 3;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        b_req   [3];
    logic        b_wren  [3];
    logic [31:0] b_addr  [3];
    logic [31:0] b_wdata [3];
    logic        if_ack, dm_ack, ex_ack;
    logic [31:0] if_rdata, dm_rdata, ex_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wren, busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (b_req[2]),
        .if_addr   (b_addr[2]),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (b_req[0]),
        .dm_wren   (b_wren[0]),
        .dm_addr   (b_addr[0]),
        .dm_wdata  (b_wdata[0]),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .ex_req    (b_req[1]),
        .ex_wren   (b_wren[1]),
        .ex_addr   (b_addr[1]),
        .ex_wdata  (b_wdata[1]),
        .ex_ack    (ex_ack),
        .ex_rdata  (ex_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // RAM: output is only valid once the address has been held LAT cycles.
    logic [31:0] ram_mem [32];
    logic [31:0] a_hist  [LAT];
    logic        mem_reinit;

    function automatic logic [31:0] mem_init(input int i);
        return (i == 4) ? 32'hDEADBEEF : {16'hC0DE, 16'(i)};
    endfunction

    always @(posedge clk) begin
        if (mem_reinit) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= mem_init(i);
        end else if (ram_wren) begin
            ram_mem[ram_addr[6:2]] <= ram_wdata;
        end
        a_hist[0] <= ram_addr;
        for (int i = 1; i < LAT; i++) a_hist[i] <= a_hist[i-1];
    end

    always_comb begin
        ram_rdata = ram_mem[ram_addr[6:2]];
        for (int i = 0; i < LAT; i++) begin
            if (a_hist[i] != ram_addr) ram_rdata = POISON;
        end
    end

    logic        d_ack [3];
    logic [31:0] d_rd  [3];
    assign d_ack[0] = dm_ack;   assign d_rd[0] = dm_rdata;
    assign d_ack[1] = ex_ack;   assign d_rd[1] = ex_rdata;
    assign d_ack[2] = if_ack;   assign d_rd[2] = if_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_overlap = 0;
    int wren_mask, hold_bad, lat, got, nack;
    int at [3];
    logic [31:0] wren_addr, hold_addr;

    // reference model state
    logic [31:0] m_mem [32];
    logic [31:0] m_rd  [3];
    logic [31:0] m_addr, m_wdata, m_val;
    logic        m_act, m_wr;
    int          m_s, m_end, m_id, free_t, rr, w, gap [3];
    int          model_acks, dut_acks;
    logic        e_busy, e_wren;
    logic        e_ack [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(if_ack) + int'(ex_ack) + int'(dm_ack) > 1) n_overlap++;
    endtask

    task automatic set_req(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d);
        b_req[p]   = 1'b1;
        b_wren[p]  = wr;
        b_addr[p]  = a;
        b_wdata[p] = d;
    endtask

    task automatic new_vals(input int p);
        b_addr[p]  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        b_wren[p]  = (p == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        b_wdata[p] = $urandom;
    endtask

    // Ticks until port p acks (bounded); lat is the cycle count, -1 on timeout.
    task automatic wait_ack(input int p, output int l);
        l = -1;
        wren_mask = 0;
        hold_bad = 0;
        for (int k = 1; k <= 30 && l < 0; k++) begin
            tick();
            if (ram_wren) begin
                wren_mask |= (1 << k);
                wren_addr = ram_addr;
            end
            if (busy && ram_addr != hold_addr) hold_bad++;
            if (d_ack[p]) l = k;
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            b_req[p] = 1'b0; b_wren[p] = 1'b0; b_addr[p] = '0; b_wdata[p] = '0;
        end
        reset_n = 1'b0;
        mem_reinit = 1'b1;
        repeat (3) tick();
        mem_reinit = 1'b0;

        chk("rst_busy",  32'(busy), 0);
        chk("rst_wren",  32'(ram_wren), 0);
        chk("rst_addr",  ram_addr, 0);
        chk("rst_rdata", dm_rdata | ex_rdata | if_rdata, 0);
        chk("rst_ack",   32'({if_ack, ex_ack, dm_ack}), 0);
        reset_n = 1'b1;

        // IF read of 0x10
        hold_addr = 32'h10;
        set_req(2, 1'b0, 32'h10, 0);
        wait_ack(2, lat);
        b_req[2] = 1'b0;
        chk("if_lat", lat, 5);
        chk("if_rdata", if_rdata, 32'hDEADBEEF);
        chk("if_no_wren", wren_mask, 0);
        tick();

        // DM write then IF readback
        hold_addr = 32'h20;
        set_req(0, 1'b1, 32'h20, 32'h12345678);
        wait_ack(0, lat);
        b_req[0] = 1'b0;
        chk("dm_wr_lat", lat, 2);
        chk("dm_wr_wren_cycles", wren_mask, 2);
        chk("dm_wr_addr", wren_addr, 32'h20);
        tick();
        set_req(2, 1'b0, 32'h20, 0);
        wait_ack(2, lat);
        b_req[2] = 1'b0;
        chk("rb_lat", lat, 5);
        chk("rb_data", if_rdata, 32'h12345678);
        tick();

        // three-way contention
        set_req(0, 1'b0, 32'h10, 0);
        set_req(1, 1'b0, 32'h20, 0);
        set_req(2, 1'b0, 32'h30, 0);
        for (int p = 0; p < 3; p++) at[p] = -1;
        got = 0;
        for (int k = 1; k <= 60 && got < 3; k++) begin
            tick();
            for (int p = 0; p < 3; p++) begin
                if (b_req[p] && d_ack[p]) begin
                    at[p] = k; b_req[p] = 1'b0; got++;
                end
            end
        end
        chk("ct_dm_at", at[0], 5);
        chk("ct_ex_at", at[1], 11);
        chk("ct_if_at", at[2], 17);
        chk("ct_dm_data", dm_rdata, 32'hDEADBEEF);
        chk("ct_ex_data", ex_rdata, 32'h12345678);
        chk("ct_if_data", if_rdata, 32'hC0DE000C);
        chk("ct_overlap", n_overlap, 0);
        tick();

        // address changed after grant
        hold_addr = 32'h20;
        set_req(0, 1'b0, 32'h20, 0);
        tick();
        chk("st_addr1", ram_addr, 32'h20);
        b_addr[0] = 32'h40;
        wait_ack(0, lat);
        b_req[0] = 1'b0;
        chk("st_lat", lat, 4);
        chk("st_hold", hold_bad, 0);
        chk("st_data", dm_rdata, 32'h12345678);
        tick();

        // reset during WAIT
        set_req(1, 1'b0, 32'h10, 0);
        tick();
        tick();
        chk("rw_busy_wait", 32'(busy), 1);
        reset_n = 1'b0;
        b_req[1] = 1'b0;
        tick();
        chk("rw_busy", 32'(busy), 0);
        chk("rw_wren", 32'(ram_wren), 0);
        chk("rw_rdata", dm_rdata | ex_rdata | if_rdata, 0);
        reset_n = 1'b1;
        nack = 0;
        repeat (10) begin
            tick();
            if (if_ack || ex_ack || dm_ack) nack++;
        end
        chk("rw_noack", nack, 0);

        // randomized phase against the transaction-level model
        reset_n = 1'b0;
        mem_reinit = 1'b1;
        tick();
        tick();
        mem_reinit = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = mem_init(i);
        for (int p = 0; p < 3; p++) begin m_rd[p] = '0; gap[p] = 0; end
        m_addr = '0; m_wdata = '0; m_val = '0; m_act = 1'b0; m_wr = 1'b0;
        m_s = 0; m_end = 0; m_id = 0; free_t = 0; rr = 0;
        model_acks = 0; dut_acks = 0;

        for (int t = 0; t < 2000; t++) begin
            if (m_act && t == m_end && !m_wr) m_rd[m_id] = m_val;
            e_busy = m_act && t >= m_s + 1 && t <= m_end;
            e_wren = m_act && m_wr && t == m_s + 1;
            for (int p = 0; p < 3; p++) begin
                e_ack[p] = m_act && t == m_end && m_id == p;
                if (e_ack[p]) model_acks++;
                if (d_ack[p]) dut_acks++;
            end

            chk($sformatf("busy@%0d", t), 32'(busy), 32'(e_busy));
            chk($sformatf("ram_wren@%0d", t), 32'(ram_wren), 32'(e_wren));
            chk($sformatf("ram_addr@%0d", t), ram_addr, m_addr);
            if (e_wren) chk($sformatf("ram_wdata@%0d", t), ram_wdata, m_wdata);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("ack%0d@%0d", p, t), 32'(d_ack[p]), 32'(e_ack[p]));
                chk($sformatf("rdata%0d@%0d", p, t), d_rd[p], m_rd[p]);
            end
            if (m_act && t == m_end) m_act = 1'b0;

            for (int p = 0; p < 3; p++) begin
                if (e_ack[p]) begin
                    b_req[p] = 1'b0;
                    gap[p] = $urandom_range(0, 3);
                end else if (!b_req[p]) begin
                    if (gap[p] > 0) gap[p]--;
                    else begin b_req[p] = 1'b1; new_vals(p); end
                end else if ($urandom_range(0, 3) == 0) begin
                    new_vals(p);
                end
            end

            if (t >= free_t) begin
                w = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                for (int k = 0; k < 3; k++) if (w < 0 && b_req[(rr + k) % 3]) w = (rr + k) % 3;
`else
                for (int p = 0; p < 3; p++) if (w < 0 && b_req[p]) w = p;
`endif
                if (w >= 0) begin
                    m_act = 1'b1;
                    m_s = t;
                    m_id = w;
                    m_wr = b_wren[w];
                    m_addr = b_addr[w];
                    if (m_wr) begin
                        m_wdata = b_wdata[w];
                        m_mem[b_addr[w][6:2]] = b_wdata[w];
                        m_end = t + 2;
                    end else begin
                        m_val = m_mem[b_addr[w][6:2]];
                        m_end = t + 2 + LAT;
                    end
                    free_t = m_end + 1;
                    rr = (w + 1) % 3;
                end
            end
            tick();
        end
        chk("ack_total", dut_acks, model_acks);

        for (int p = 0; p < 3; p++) b_req[p] = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
